data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Two-requester arbiter in front of the single-port data memory (sync write,
//  combinational read). Port A is the CPU load/store path; port B is the
//  DMA/program-loader path. The block serialises access with round-robin
//  fairness and optional locked bursts capped by a starvation guard. It
//  registers read data back to the owning requester.
// PARAMETERS
//  ADDR_W    32  address width (byte address, passed through unchanged)
//  DATA_W    32  data word width
//  MAX_HOLD  4   max consecutive locked beats while the other port requests (>=1)
// PORTS
//  CLK            in   1       clock, all state on posedge
//  Reset_n        in   1       asynchronous active-low reset
//  A_Req/B_Req    in   1       access request; hold all fields stable until own Gnt=1
//  A_Lock/B_Lock  in   1       keep ownership for a following beat
//  A_Write/B_Write in  1       1=write, 0=read
//  A_Address/B_Address in ADDR_W  request address
//  A_WriteData/B_WriteData in DATA_W  write data
//  A_Gnt/B_Gnt    out  1       beat performed this cycle
//  A_RdValid/B_RdValid out 1   one-cycle pulse: RdData holds read result
//  A_RdData/B_RdData out DATA_W  registered read data, held until next read
//  MemAddress     out  ADDR_W  to memory Address
//  MemWriteData   out  DATA_W  to memory WriteData
//  MemWrite       out  1       to memory MemWrite
//  MemReadData    in   DATA_W  from memory ReadData (combinational)
// BEHAVIOUR
//  - FSM states IDLE, OWN_A, OWN_B (registered). HoldCnt counts beats in current ownership.
//  - A_Gnt = (state==OWN_A) & A_Req; B_Gnt likewise. Gnts are never both 1.
//  - Mem mux (combinational): owner's Address/WriteData. MemWrite = X_Gnt & X_Write.
//    In IDLE, or when the owner's Req=0: MemAddress=0, MemWriteData=0, MemWrite=0.
//  - A write commits at the edge ending its Gnt cycle.
//  - On a read beat, MemReadData is captured into X_RdData at the edge ending the
//    Gnt cycle. X_RdValid=1 for the following cycle.
//  - Latency: Req high at edge k (state IDLE) -> Gnt in cycle k+1 -> RdValid in cycle k+2.
//  - IDLE at edge: grant the only requester. If both request, grant the port not
//    equal to Last. Last resets to B, so A wins first.
//  - OWN_X at edge, continue ownership iff X_Req & X_Lock & (HoldCnt<MAX_HOLD-1 | ~Y_Req).
//    Otherwise go to OWN_Y if Y_Req, else IDLE.
//  - An unlocked beat releases ownership, and X_Req at that edge is treated as the
//    serviced request. The requester drops Req or presents a new request next cycle.
//  - Ownership change (OWN or IDLE entry): HoldCnt=0, Last updated to the new owner.
//    Each continued beat: HoldCnt+1, saturating at MAX_HOLD-1.
//  - Locked owner with Req=0 in a cycle: no access, Gnt=0. Ownership releases at
//    that edge when Lock=0.
//  - Direct OWN_A->OWN_B handover: no bubble. B_Gnt is possible in the cycle after A's last beat.
//  - Reset (async, Reset_n=0): state=IDLE, Last=B, HoldCnt=0, Gnt=0, RdValid=0,
//    RdData=0, MemWrite=0 immediately.
//  - Reset mid-beat: no write commits, pending RdValid is dropped.
// TESTING
//  1 Reset with A_Req=1 write 0x10<-0xDEADBEEF: A_Gnt=0, MemWrite=0 during reset.
//    After release, A_Gnt=1 next cycle; mem[4]=0xDEADBEEF.
//  2 A read 0x10 alone: A_Gnt in cycle k+1, A_RdValid in k+2, A_RdData=0xDEADBEEF,
//    B_RdValid stays 0.
//  3 A_Req and B_Req both high from IDLE, unlocked, held continuously: grants
//    A,B,A,B on consecutive cycles.
//  4 A locked 8-beat write burst 0x0..0x1C with B idle: 8 consecutive A_Gnt.
//    Same burst with B_Req=1: 4 A beats, 1 B beat, then A resumes.
//  5 A locked with Req=0 in cycle 2 and Lock=0: no MemWrite that cycle; B gets
//    B_Gnt the next cycle.
//  6 Assert Reset_n=0 during a B write Gnt cycle to 0x20 <- 0x1234: mem[8] unchanged,
//    state IDLE, all outputs 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin arbiter with capped locked bursts in front of a
// single-port data memory; read results are registered back to the owning port.
module data_memory_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              A_Req,
    input  logic              A_Lock,
    input  logic              A_Write,
    input  logic [ADDR_W-1:0] A_Address,
    input  logic [DATA_W-1:0] A_WriteData,
    output logic              A_Gnt,
    output logic              A_RdValid,
    output logic [DATA_W-1:0] A_RdData,
    input  logic              B_Req,
    input  logic              B_Lock,
    input  logic              B_Write,
    input  logic [ADDR_W-1:0] B_Address,
    input  logic [DATA_W-1:0] B_WriteData,
    output logic              B_Gnt,
    output logic              B_RdValid,
    output logic [DATA_W-1:0] B_RdData,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              last_b_r;       // 1: B was the most recent owner
    logic              last_b_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              hold_room_s;
    logic              a_keep_s;
    logic              b_keep_s;
    logic              a_gnt_s;
    logic              b_gnt_s;
    logic              a_rd_valid_r;
    logic              b_rd_valid_r;
    logic [DATA_W-1:0] a_rd_data_r;
    logic [DATA_W-1:0] b_rd_data_r;

    assign a_gnt_s     = (state_r == ST_OWN_A) & A_Req;
    assign b_gnt_s     = (state_r == ST_OWN_B) & B_Req;
    assign hold_room_s = (hold_cnt_r < HOLD_LIMIT);
    // A locked owner may only overrun the hold cap while the other port is quiet.
    assign a_keep_s    = A_Req & A_Lock & (hold_room_s | ~B_Req);
    assign b_keep_s    = B_Req & B_Lock & (hold_room_s | ~A_Req);

    assign A_Gnt     = a_gnt_s;
    assign B_Gnt     = b_gnt_s;
    assign A_RdValid = a_rd_valid_r;
    assign B_RdValid = b_rd_valid_r;
    assign A_RdData  = a_rd_data_r;
    assign B_RdData  = b_rd_data_r;

    // Memory port mux: only a granted beat drives the memory.
    always_comb begin
        MemAddress   = {ADDR_W{1'b0}};
        MemWriteData = {DATA_W{1'b0}};
        MemWrite     = 1'b0;
        if (a_gnt_s) begin
            MemAddress   = A_Address;
            MemWriteData = A_WriteData;
            MemWrite     = A_Write;
        end else if (b_gnt_s) begin
            MemAddress   = B_Address;
            MemWriteData = B_WriteData;
            MemWrite     = B_Write;
        end else begin
            MemAddress   = {ADDR_W{1'b0}};
            MemWriteData = {DATA_W{1'b0}};
            MemWrite     = 1'b0;
        end
    end

    // Ownership decision for the next cycle.
    always_comb begin
        state_nxt_s    = state_r;
        last_b_nxt_s   = last_b_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (A_Req && (!B_Req || last_b_r)) begin
                    state_nxt_s    = ST_OWN_A;
                    last_b_nxt_s   = 1'b0;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else if (B_Req) begin
                    state_nxt_s    = ST_OWN_B;
                    last_b_nxt_s   = 1'b1;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end
            end
            ST_OWN_A: begin
                if (a_keep_s) begin
                    state_nxt_s = ST_OWN_A;
                    if (hold_room_s) begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r;
                    end
                end else if (B_Req) begin
                    state_nxt_s    = ST_OWN_B;
                    last_b_nxt_s   = 1'b1;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end
            end
            ST_OWN_B: begin
                if (b_keep_s) begin
                    state_nxt_s = ST_OWN_B;
                    if (hold_room_s) begin
                        hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r;
                    end
                end else if (A_Req) begin
                    state_nxt_s    = ST_OWN_A;
                    last_b_nxt_s   = 1'b0;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s    = ST_IDLE;
                    hold_cnt_nxt_s = {HOLD_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                hold_cnt_nxt_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            last_b_r   <= 1'b1;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            last_b_r   <= last_b_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    // Read return: capture memory data at the end of a read beat, pulse valid once.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            a_rd_valid_r <= 1'b0;
            b_rd_valid_r <= 1'b0;
            a_rd_data_r  <= {DATA_W{1'b0}};
            b_rd_data_r  <= {DATA_W{1'b0}};
        end else begin
            a_rd_valid_r <= a_gnt_s & ~A_Write;
            b_rd_valid_r <= b_gnt_s & ~B_Write;
            if (a_gnt_s && !A_Write) begin
                a_rd_data_r <= MemReadData;
            end
            if (b_gnt_s && !B_Write) begin
                b_rd_data_r <= MemReadData;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a transaction-level ownership model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_data_memory_arbiter;

    localparam int MAX_HOLD = 4;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        A_Req, A_Lock, A_Write, B_Req, B_Lock, B_Write;
    logic [31:0] A_Address, A_WriteData, B_Address, B_WriteData;
    logic        A_Gnt, A_RdValid, B_Gnt, B_RdValid, MemWrite;
    logic [31:0] A_RdData, B_RdData, MemAddress, MemWriteData, MemReadData;

    logic [31:0] mem   [0:63] = '{default: 32'h0};
    logic [31:0] m_mem [0:63] = '{default: 32'h0};

    int n_checks = 0;
    int n_pass   = 0;

    int          m_own  = 0;     // 0 none, 1 A, 2 B
    int          m_last = 2;
    int          m_run  = 0;     // beats performed in current ownership
    logic        m_rdv_a = 1'b0, m_rdv_b = 1'b0;
    logic [31:0] m_rdd_a = 32'h0, m_rdd_b = 32'h0;

    logic [1:0] glog [0:63];
    int         glen;

    always #5 CLK = ~CLK;

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .A_Req(A_Req), .A_Lock(A_Lock), .A_Write(A_Write), .A_Address(A_Address),
        .A_WriteData(A_WriteData), .A_Gnt(A_Gnt), .A_RdValid(A_RdValid), .A_RdData(A_RdData),
        .B_Req(B_Req), .B_Lock(B_Lock), .B_Write(B_Write), .B_Address(B_Address),
        .B_WriteData(B_WriteData), .B_Gnt(B_Gnt), .B_RdValid(B_RdValid), .B_RdData(B_RdData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
        .MemReadData(MemReadData)
    );

    assign MemReadData = mem[MemAddress[7:2]];

    always @(posedge CLK) begin
        if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic req_of(int p);
        return (p == 1) ? A_Req : B_Req;
    endfunction
    function automatic logic lock_of(int p);
        return (p == 1) ? A_Lock : B_Lock;
    endfunction
    function automatic logic write_of(int p);
        return (p == 1) ? A_Write : B_Write;
    endfunction
    function automatic logic [31:0] addr_of(int p);
        return (p == 1) ? A_Address : B_Address;
    endfunction
    function automatic logic [31:0] wdata_of(int p);
        return (p == 1) ? A_WriteData : B_WriteData;
    endfunction
    function automatic int widx(int p);
        logic [31:0] a;
        a = addr_of(p);
        return int'(a[7:2]);
    endfunction
    function automatic int served();
        return (m_own != 0 && req_of(m_own)) ? m_own : 0;
    endfunction

    // Reference model: who owns the memory, who went last, how long the run is.
    always @(posedge CLK or negedge Reset_n) begin
        int g, nxt, other;
        if (!Reset_n) begin
            m_own   <= 0;
            m_last  <= 2;
            m_run   <= 0;
            m_rdv_a <= 1'b0;
            m_rdv_b <= 1'b0;
            m_rdd_a <= 32'h0;
            m_rdd_b <= 32'h0;
        end else begin
            g = served();
            m_rdv_a <= (g == 1) && !A_Write;
            m_rdv_b <= (g == 2) && !B_Write;
            if (g == 1 && !A_Write) m_rdd_a <= m_mem[widx(1)];
            if (g == 2 && !B_Write) m_rdd_b <= m_mem[widx(2)];
            if (g != 0 && write_of(g)) m_mem[widx(g)] <= wdata_of(g);
            if (m_own == 0) begin
                if (A_Req && B_Req) nxt = (m_last == 1) ? 2 : 1;
                else if (A_Req)     nxt = 1;
                else if (B_Req)     nxt = 2;
                else                nxt = 0;
            end else begin
                other = 3 - m_own;
                if (req_of(m_own) && lock_of(m_own) && (m_run < MAX_HOLD || !req_of(other)))
                    nxt = m_own;
                else
                    nxt = req_of(other) ? other : 0;
            end
            if (nxt != 0 && nxt == m_own) begin
                m_run <= m_run + 1;
            end else if (nxt != 0) begin
                m_run  <= 1;
                m_last <= nxt;
            end
            m_own <= nxt;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        int g;
        g = served();
        chk("a_gnt", 32'(A_Gnt), 32'(g == 1));
        chk("b_gnt", 32'(B_Gnt), 32'(g == 2));
        chk("mem_write", 32'(MemWrite), 32'(g != 0 && write_of(g)));
        chk("mem_addr", MemAddress, (g != 0) ? addr_of(g) : 32'h0);
        chk("mem_wdata", MemWriteData, (g != 0) ? wdata_of(g) : 32'h0);
        chk("a_rdvalid", 32'(A_RdValid), 32'(m_rdv_a));
        chk("b_rdvalid", 32'(B_RdValid), 32'(m_rdv_b));
        chk("a_rddata", A_RdData, m_rdd_a);
        chk("b_rddata", B_RdData, m_rdd_b);
    end

    task automatic run_burst(input int n, input bit with_b);
        int beat, cy;
        bit b_done, started, ag, bg;
        beat = 0; cy = 0; b_done = !with_b; started = 1'b0; glen = 0;
        A_Req = 1'b1; A_Lock = (n > 1); A_Write = 1'b1;
        A_Address = 32'h0; A_WriteData = 32'hA500_0000;
        B_Req = 1'b0; B_Lock = 1'b0; B_Write = 1'b1;
        B_Address = 32'h40; B_WriteData = 32'h0000_B0B0;
        while ((beat < n || !b_done) && cy < 40) begin
            @(negedge CLK);
            ag = A_Gnt; bg = B_Gnt;
            if (ag || bg) started = 1'b1;
            if (started && glen < 64) begin
                glog[glen] = {ag, bg};
                glen++;
            end
            cyc();
            cy++;
            if (ag) begin
                beat++;
                if (beat < n) begin
                    A_Address   = 32'(beat * 4);
                    A_WriteData = 32'hA500_0000 + 32'(beat);
                    A_Lock      = (beat < n - 1);
                end else begin
                    A_Req  = 1'b0;
                    A_Lock = 1'b0;
                end
                if (with_b && !b_done && beat == 1) B_Req = 1'b1;
            end
            if (bg) begin
                B_Req  = 1'b0;
                b_done = 1'b1;
            end
        end
        chk("burst_beats", 32'(beat), 32'(n));
        chk("burst_b_done", 32'(b_done), 32'h1);
        A_Req = 1'b0; B_Req = 1'b0;
        cyc(); cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat [0:3];
        Reset_n = 1'b0;
        A_Req = 1'b1; A_Lock = 1'b0; A_Write = 1'b1;
        A_Address = 32'h10; A_WriteData = 32'hDEADBEEF;
        B_Req = 1'b0; B_Lock = 1'b0; B_Write = 1'b0;
        B_Address = 32'h0; B_WriteData = 32'h0;

        // 1: request held through reset, granted right after release
        repeat (3) cyc();
        @(negedge CLK);
        chk("t1_rst_a_gnt", 32'(A_Gnt), 32'h0);
        chk("t1_rst_memwrite", 32'(MemWrite), 32'h0);
        cyc(); Reset_n = 1'b1;
        cyc(); @(negedge CLK);
        chk("t1_a_gnt", 32'(A_Gnt), 32'h1);
        chk("t1_memwrite", 32'(MemWrite), 32'h1);
        cyc(); A_Req = 1'b0;
        @(negedge CLK);
        chk("t1_mem4", mem[4], 32'hDEADBEEF);

        // 2: lone A read, data returns one cycle after the grant
        A_Req = 1'b1; A_Write = 1'b0; A_Address = 32'h10;
        cyc(); @(negedge CLK);
        chk("t2_a_gnt", 32'(A_Gnt), 32'h1);
        cyc(); A_Req = 1'b0;
        @(negedge CLK);
        chk("t2_a_rdvalid", 32'(A_RdValid), 32'h1);
        chk("t2_a_rddata", A_RdData, 32'hDEADBEEF);
        chk("t2_b_rdvalid", 32'(B_RdValid), 32'h0);
        cyc(); @(negedge CLK);
        chk("t2_a_rdvalid_drop", 32'(A_RdValid), 32'h0);

        // 3: fresh reset, both ports request unlocked: strict alternation, A first
        cyc(); Reset_n = 1'b0;
        cyc(); Reset_n = 1'b1;
        A_Req = 1'b1; A_Write = 1'b0; A_Address = 32'h10;
        B_Req = 1'b1; B_Write = 1'b0; B_Address = 32'h14;
        for (int i = 0; i < 4; i++) begin
            cyc(); @(negedge CLK);
            pat[i] = {A_Gnt, B_Gnt};
        end
        chk("t3_gnt0", 32'(pat[0]), 32'h2);
        chk("t3_gnt1", 32'(pat[1]), 32'h1);
        chk("t3_gnt2", 32'(pat[2]), 32'h2);
        chk("t3_gnt3", 32'(pat[3]), 32'h1);
        cyc(); A_Req = 1'b0; B_Req = 1'b0;
        cyc(); cyc();

        // 4a: locked 8-beat burst with B idle runs uninterrupted
        run_burst(8, 1'b0);
        chk("t4a_len", 32'(glen), 32'd8);
        for (int i = 0; i < 8; i++) chk("t4a_seq", 32'(glog[i]), 32'h2);

        // 4b: same burst with B requesting: 4 A beats, 1 B beat, A resumes
        run_burst(8, 1'b1);
        chk("t4b_len", 32'(glen), 32'd9);
        for (int i = 0; i < 9; i++) chk("t4b_seq", 32'(glog[i]), (i == 4) ? 32'h1 : 32'h2);
        chk("t4b_mem7", mem[7], 32'hA500_0007);
        chk("t4b_mem16", mem[16], 32'h0000_B0B0);

        // 5: locked A drops Req with Lock=0: idle beat, then B served
        A_Req = 1'b1; A_Lock = 1'b1; A_Write = 1'b1;
        A_Address = 32'h30; A_WriteData = 32'h5555_5555;
        cyc(); @(negedge CLK);
        chk("t5_a_gnt", 32'(A_Gnt), 32'h1);
        cyc();
        A_Req = 1'b0; A_Lock = 1'b0;
        B_Req = 1'b1; B_Lock = 1'b0; B_Write = 1'b0; B_Address = 32'h30;
        @(negedge CLK);
        chk("t5_memwrite", 32'(MemWrite), 32'h0);
        chk("t5_a_gnt_off", 32'(A_Gnt), 32'h0);
        cyc(); @(negedge CLK);
        chk("t5_b_gnt", 32'(B_Gnt), 32'h1);
        cyc(); B_Req = 1'b0;
        @(negedge CLK);
        chk("t5_b_rddata", B_RdData, 32'h5555_5555);
        cyc();

        // 6: reset lands mid B write beat: no commit, everything cleared at once
        B_Req = 1'b1; B_Write = 1'b1; B_Address = 32'h20; B_WriteData = 32'h0000_1234;
        cyc(); @(negedge CLK);
        chk("t6_b_gnt", 32'(B_Gnt), 32'h1);
        #1 Reset_n = 1'b0;
        #1;
        chk("t6_b_gnt_rst", 32'(B_Gnt), 32'h0);
        chk("t6_memwrite_rst", 32'(MemWrite), 32'h0);
        chk("t6_memaddr_rst", MemAddress, 32'h0);
        chk("t6_a_rddata_rst", A_RdData, 32'h0);
        chk("t6_b_rddata_rst", B_RdData, 32'h0);
        chk("t6_rdvalid_rst", 32'({A_RdValid, B_RdValid}), 32'h0);
        cyc(); B_Req = 1'b0;
        @(negedge CLK);
        chk("t6_mem8", mem[8], 32'h0);
        Reset_n = 1'b1;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
